// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps exactly one imem request in flight and
// presents fetched words to decode. Optional misaligned-redirect trap: PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        misaligned_err
);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        ERR  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;
`endif

    state_t      state_r;
    state_t      redir_dest_s;
    state_t      kill_dest_s;
    logic [31:0] pc_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic [31:0] redir_tgt_s;
    logic        kill_r;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic        redir_mis_s;
    logic        err_pend_r;

    assign redir_mis_s = |redir_target[1:0];
`endif

    assign imem_req_valid = (state_r == REQ);
    assign imem_addr      = pc_r;
    assign if_valid       = (state_r == OUT);
    assign if_pc          = if_pc_r;
    assign if_instr       = if_instr_r;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    assign misaligned_err = (state_r == ERR);
`else
    assign misaligned_err = 1'b0;
`endif

    // Redirect target and the state entered after a redirect or after a discarded response
    always_comb begin
        redir_tgt_s  = redir_target & 32'hFFFF_FFFC;
        redir_dest_s = REQ;
        kill_dest_s  = REQ;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        redir_tgt_s  = redir_target;
        redir_dest_s = redir_mis_s ? ERR : REQ;
        kill_dest_s  = err_pend_r ? ERR : REQ;
`endif
    end

    // Fetch state machine, PC and presented-instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_VECTOR;
            kill_r     <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= 32'h0000_0000;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            err_pend_r <= 1'b0;
`endif
        end else if (redir_valid) begin
            pc_r <= redir_tgt_s;
            case (state_r)
                REQ: begin
                    // An accepted old-path request still owes us one response to drop
                    if (imem_req_ready) begin
                        state_r <= WAIT;
                        kill_r  <= 1'b1;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                        err_pend_r <= redir_mis_s;
`endif
                    end else begin
                        state_r <= redir_dest_s;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_r <= redir_dest_s;
                        kill_r  <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                        err_pend_r <= 1'b0;
`endif
                    end else begin
                        kill_r <= 1'b1;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                        err_pend_r <= redir_mis_s;
`endif
                    end
                end
                default: begin
                    state_r <= redir_dest_s;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                    err_pend_r <= 1'b0;
`endif
                end
            endcase
        end else begin
            case (state_r)
                IDLE: state_r <= REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_r) begin
                            kill_r  <= 1'b0;
                            state_r <= kill_dest_s;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                            err_pend_r <= 1'b0;
`endif
                        end else begin
                            if_instr_r <= imem_rsp_data;
                            if_pc_r    <= pc_r;
                            state_r    <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (if_ready) begin
                        pc_r    <= pc_r + 32'd4;
                        state_r <= REQ;
                    end
                end
                default: state_r <= state_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with a behavioural single-outstanding
// instruction memory; honours PC_FETCH_MISALIGN_TRAP_EN when defined.
module tb_pc_fetch_ctrl;
    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        misaligned_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rsp_cnt = 0;
    int          saw_dead = 0;
    logic [31:0] rsp_addr = 32'h0;
    logic [31:0] ovr_addr = 32'h0000_0001;
    logic [31:0] iss_addr[$];
    int          iss_cyc[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];

    pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .redir_valid(redir_valid), .redir_target(redir_target), .misaligned_err(misaligned_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model and monitors, evaluated on the falling edge
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (rst) begin
                rsp_cnt = 0;
            end else begin
                if (if_valid && if_ready && !redir_valid) begin
                    dlv_pc.push_back(if_pc);
                    dlv_instr.push_back(if_instr);
                end
                if (if_valid && if_instr == 32'hDEAD_BEEF) saw_dead++;
                if (rsp_cnt != 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = (rsp_addr == ovr_addr) ? 32'hDEAD_BEEF : mem_word(rsp_addr);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    rsp_cnt  = lat;
                    rsp_addr = imem_addr;
                    iss_addr.push_back(imem_addr);
                    iss_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        iss_addr.delete();
        iss_cyc.delete();
        dlv_pc.delete();
        dlv_instr.delete();
        saw_dead = 0;
    endtask

    function automatic logic cond_met(input int sel, input int n);
        case (sel)
            0:       return iss_addr.size() >= n;
            1:       return dlv_pc.size() >= n;
            2:       return if_valid;
            3:       return imem_req_valid;
            default: return imem_req_valid && imem_req_ready;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int n);
        int k;
        k = 0;
        while (!cond_met(sel, n) && k < 60) begin
            tick();
            k++;
        end
        check_eq(tag, {31'd0, cond_met(sel, n)}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    // Park the fetcher in REQ (memory stalled) and redirect it to t
    task automatic setup_pc(input logic [31:0] t);
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        lat            = 1;
        ovr_addr       = 32'h0000_0001;
        do_reset();
        wait_for("setup_req", 3, 0);
        redir_valid  = 1'b1;
        redir_target = t;
        tick();
        redir_valid = 1'b0;
        clear_logs();
    endtask

    initial begin
        int bad;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        redir_valid = 1'b0;
        redir_target = 32'h0;
        tick();
        tick();
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_instr", if_instr, 32'h0);
        check_eq("rst_mis", {31'd0, misaligned_err}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0000_0100);

        // Streaming fetch at full rate
        rst = 1'b0;
        clear_logs();
        wait_for("t1_wait", 1, 3);
        check_eq("t1_iss0", iss_addr[0], 32'h0000_0100);
        check_eq("t1_iss1", iss_addr[1], 32'h0000_0104);
        check_eq("t1_iss2", iss_addr[2], 32'h0000_0108);
        check_eq("t1_pc0", dlv_pc[0], 32'h0000_0100);
        check_eq("t1_pc2", dlv_pc[2], 32'h0000_0108);
        check_eq("t1_instr1", dlv_instr[1], 32'h1357_9ADB);
        check_eq("t1_cad01", 32'(iss_cyc[1] - iss_cyc[0]), 32'd3);
        check_eq("t1_cad12", 32'(iss_cyc[2] - iss_cyc[1]), 32'd3);

        // Decode back-pressure
        if_ready = 1'b0;
        wait_for("t2_wait", 2, 0);
        check_eq("t2_pc", if_pc, 32'h0000_010C);
        check_eq("t2_instr", if_instr, 32'h1357_9AD3);
        hold_pc = if_pc;
        hold_instr = if_instr;
        clear_logs();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if_pc !== hold_pc || if_instr !== hold_instr || imem_req_valid || !if_valid) bad++;
        end
        check_eq("t2_stable", 32'(bad), 32'd0);
        check_eq("t2_noreq", 32'(iss_addr.size()), 32'd0);
        if_ready = 1'b1;
        wait_for("t2_next", 0, 1);
        check_eq("t2_addr", iss_addr[0], 32'h0000_0110);

        // Redirect while waiting for a slow response
        lat = 3;
        ovr_addr = 32'h0000_0100;
        do_reset();
        wait_for("t3_acc", 4, 0);
        tick();
        redir_valid = 1'b1;
        redir_target = 32'h0000_2000;
        tick();
        redir_valid = 1'b0;
        clear_logs();
        wait_for("t3_dlv", 1, 1);
        check_eq("t3_iss", iss_addr[0], 32'h0000_2000);
        check_eq("t3_pc", dlv_pc[0], 32'h0000_2000);
        check_eq("t3_instr", dlv_instr[0], 32'h1357_BBDF);
        check_eq("t3_dead", 32'(saw_dead), 32'd0);

        // Redirect in the same cycle the request is accepted
        setup_pc(32'h0000_0010);
        check_eq("t4_addr", imem_addr, 32'h0000_0010);
        ovr_addr = 32'h0000_0010;
        lat = 2;
        imem_req_ready = 1'b1;
        redir_valid = 1'b1;
        redir_target = 32'h0000_0400;
        tick();
        redir_valid = 1'b0;
        wait_for("t4_dlv", 1, 1);
        check_eq("t4_iss0", iss_addr[0], 32'h0000_0010);
        check_eq("t4_iss1", iss_addr[1], 32'h0000_0400);
        check_eq("t4_pc", dlv_pc[0], 32'h0000_0400);
        check_eq("t4_dead", 32'(saw_dead), 32'd0);

        // PC wrap-around
        setup_pc(32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        wait_for("t5_dlv", 1, 2);
        check_eq("t5_iss0", iss_addr[0], 32'hFFFF_FFFC);
        check_eq("t5_iss1", iss_addr[1], 32'h0000_0000);
        check_eq("t5_pc1", dlv_pc[1], 32'h0000_0000);

        // Redirect in OUT while decode is ready: held instruction is dropped
        setup_pc(32'h0000_0600);
        if_ready = 1'b0;
        imem_req_ready = 1'b1;
        wait_for("t7_out", 2, 0);
        check_eq("t7_pc", if_pc, 32'h0000_0600);
        if_ready = 1'b1;
        redir_valid = 1'b1;
        redir_target = 32'h0000_0700;
        tick();
        redir_valid = 1'b0;
        check_eq("t7_nodlv", 32'(dlv_pc.size()), 32'd0);
        wait_for("t7_dlv", 1, 1);
        check_eq("t7_pc2", dlv_pc[0], 32'h0000_0700);

        // Misaligned redirect target
        setup_pc(32'h0000_2002);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        check_eq("t6_mis", {31'd0, misaligned_err}, 32'd1);
        check_eq("t6_req", {31'd0, imem_req_valid}, 32'd0);
        check_eq("t6_addr", imem_addr, 32'h0000_2002);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("t6_noreq", 32'(iss_addr.size()), 32'd0);
        check_eq("t6_noout", {31'd0, if_valid}, 32'd0);
        redir_valid = 1'b1;
        redir_target = 32'h0000_3000;
        tick();
        redir_valid = 1'b0;
        check_eq("t6_clr", {31'd0, misaligned_err}, 32'd0);
        wait_for("t6_dlv", 1, 1);
        check_eq("t6_iss", iss_addr[0], 32'h0000_3000);
        check_eq("t6_pc", dlv_pc[0], 32'h0000_3000);
`else
        check_eq("t6_addr", imem_addr, 32'h0000_2000);
        check_eq("t6_mis", {31'd0, misaligned_err}, 32'd0);
        imem_req_ready = 1'b1;
        wait_for("t6_dlv", 1, 1);
        check_eq("t6_iss", iss_addr[0], 32'h0000_2000);
        check_eq("t6_pc", dlv_pc[0], 32'h0000_2000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Instruction-fetch sequencer for the RV32 core. It owns the program counter and issues one instruction-memory request at a time. It presents each returned instruction with its PC to decode through a valid/ready handshake, and applies branch/jump redirects, discarding any in-flight or held instruction from the old path.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  32  fetch address (current PC)
imem_rsp_valid  input  1  instruction data returned (earliest: cycle after acceptance)
imem_rsp_data  input  32  returned instruction word
if_valid  output  1  instruction presented to decode
if_ready  input  1  decode accepts instruction
if_pc  output  32  PC of presented instruction
if_instr  output  32  presented instruction word
redir_valid  input  1  redirect request (branch/jump/trap)
redir_target  input  32  redirect target PC
misaligned_err  output  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Reset (rst high at posedge): pc=RESET_VECTOR, state=IDLE, kill=0, if_pc=0, if_instr=0, misaligned_err=0. While in reset or IDLE, imem_req_valid=0 and if_valid=0.
- States: IDLE, REQ, WAIT, OUT (plus ERR with the optional feature).
- Combinational outputs: imem_req_valid=(state==REQ); imem_addr=pc; if_valid=(state==OUT).
- IDLE -> REQ unconditionally. The first request is visible in the 2nd cycle after rst is released.
- REQ: on imem_req_ready, go to WAIT. Otherwise hold, keeping imem_addr stable.
- WAIT: on imem_rsp_valid:
  - kill=0: latch if_instr=imem_rsp_data and if_pc=pc, then go to OUT.
  - kill=1: discard the data, clear kill, go to REQ.
- OUT: hold if_instr and if_pc stable until if_ready. On if_valid&&if_ready: pc<=pc+4, go to REQ.
- Minimum cadence is 3 cycles per instruction. Exactly one request is outstanding at any time.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Redirect has priority over every other transition in any non-reset state; pc<=redir_target.
  - IDLE/REQ with no acceptance this cycle: go to REQ. The next request uses the new pc.
  - REQ with imem_req_ready in the same cycle: the old-path request counts as issued. Go to WAIT with kill=1.
  - WAIT, no rsp this cycle: stay in WAIT, kill=1.
  - WAIT, rsp in the same cycle: drop the data, go to REQ, kill=0.
  - OUT: drop the held instruction (even if if_ready is high this cycle; that handshake does not advance pc), go to REQ.
- A second redirect while kill=1 only updates pc; one response is still discarded.
- imem_rsp_valid outside WAIT is ignored.
- rst mid-operation returns to IDLE and clears kill. A response belonging to a pre-reset request arriving later is ignored because state is IDLE/REQ.

Optional Feature:
Macro: PC_FETCH_MISALIGN_TRAP_EN.
- Defined: redirect with redir_target[1:0]!=0 enters ERR. In ERR, misaligned_err=1, imem_req_valid=0, if_valid=0, and pc holds the misaligned target. An aligned redirect in ERR clears misaligned_err and follows the normal redirect rules (from ERR, go to REQ). A misaligned redirect while WAIT is pending sets kill=1 and enters ERR only after the discarded response arrives.
- Not defined: redir_target[1:0] is forced to 2'b00, there is no ERR state, and misaligned_err is tied to 0.

Test Plan:
- Reset with RESET_VECTOR=32'h100, memory always ready, 1-cycle latency, if_ready=1 -> addresses 0x100, 0x104, 0x108 issued; if_pc matches each; one instruction every 3 cycles.
- Hold if_ready=0 for 5 cycles in OUT -> if_instr/if_pc stable, no new request; release -> next request at pc+4.
- Redirect to 0x2000 while in WAIT, rsp arrives 3 cycles later with 0xDEADBEEF -> data never appears on if_valid; next request addr=0x2000.
- Redirect in the same cycle as imem_req_ready for 0x10 -> the 0x10 response is discarded; first presented if_pc=target.
- pc=0xFFFF_FFFC instruction accepted -> next imem_addr=0x0000_0000.
- Redirect to 0x2002 -> with the macro: misaligned_err=1, no requests until a redirect to 0x3000, then fetch at 0x3000. Without the macro: fetch at 0x2000.
